mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one unified memory port between the instruction-fetch requester (icache side of the PC/IF path) and the load/store requester (dcache side of the ID/MEM path).
- Sits between the core's icache/dcache request signals and the external memory model or bus.
- Arbitrates round-robin, latches the granted request, and drives a valid/ready request handshake toward memory.
- Keeps one transaction outstanding and returns the response to the requester that issued it, with a flush path for fetches on branch redirect.

Parameters:
- ADDR_W, 32, address width (matches AddrBus).
- DATA_W, 32, data width (matches DataBus/InstBus).

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- icache_req_valid_i  in  1  fetch request pending.
- icache_addr_i  in  ADDR_W  fetch address.
- icache_flush_i  in  1  discard pending fetch (branch redirect).
- icache_ready_o  out  1  fetch request accepted this cycle.
- icache_data_valid_o  out  1  one-cycle fetch response strobe.
- icache_data_o  out  DATA_W  fetched instruction.
- dcache_req_valid_i  in  1  load/store request pending.
- dcache_addr_i  in  ADDR_W  load/store address.
- dcache_wen_i  in  1  1 = store.
- dcache_wdata_i  in  DATA_W  store data.
- dcache_wlen_i  in  2  store size code, passed through unchanged.
- dcache_ready_o  out  1  load/store request accepted this cycle.
- dcache_data_valid_o  out  1  one-cycle load data or store completion strobe.
- dcache_data_o  out  DATA_W  load data.
- mem_req_valid_o  out  1  request to memory.
- mem_req_ready_i  in  1  memory accepts request.
- mem_addr_o  out  ADDR_W  latched address.
- mem_wen_o  out  1  latched write enable.
- mem_wdata_o  out  DATA_W  latched store data.
- mem_wlen_o  out  2  latched store size.
- mem_rvalid_i  in  1  response/ack from memory, one per request.
- mem_rdata_i  in  DATA_W  response data.

Behaviour:
- States: IDLE, REQ, WAIT. Registers: state, owner (0 = I, 1 = D), last_grant, drop, and latched addr/wen/wdata/wlen.
- Reset:
  - state = IDLE, last_grant = I, drop = 0.
  - All outputs 0, including the latched mem_* fields and both data_o.
  - Reset mid-transaction abandons it; no response is delivered.
- Arbitration in IDLE (combinational ready):
  - The effective fetch request is icache_req_valid_i & ~icache_flush_i.
  - One requester pending: grant it.
  - Both pending: grant the one not equal to last_grant, so D wins the first tie after reset.
  - Granted ready_o = 1 only in IDLE; ready_o is never 1 for both requesters at once.
- Grant edge:
  - Latch the requester's fields. For a fetch, wen = 0, wdata = 0, wlen = 0.
  - owner = granted requester, last_grant = granted requester, drop = 0, state -> REQ.
- REQ:
  - mem_req_valid_o = 1 and all mem_* fields stay stable until mem_req_ready_i = 1.
  - No withdrawal, including under flush.
  - On mem_req_ready_i = 1 -> WAIT.
- WAIT:
  - On mem_rvalid_i, register mem_rdata_i into the owner's data_o.
  - Next cycle the owner's data_valid_o = 1 for exactly one cycle, and state = IDLE.
  - The new IDLE cycle may grant immediately.
  - data_o holds its value until the next response to that owner.
- A response arriving in the same cycle as mem_req_ready_i is not legal; memory responds at least one cycle after accept.
- Stores: dcache_data_valid_o pulses on the ack; dcache_data_o is updated with mem_rdata_i (don't-care content).
- Flush:
  - icache_flush_i = 1 while owner = I in REQ or WAIT sets drop = 1.
  - The transaction completes normally on the memory side, but icache_data_valid_o stays 0 and icache_data_o is not updated.
  - Flush has no effect on a D transaction.
  - Flush on the exact rvalid cycle also drops the response.
- Minimum latency: grant at T, mem_req_valid_o at T+1, earliest rvalid at T+2, data_valid_o at T+3.
- Throughput: one transaction at a time; back-to-back grants are separated by that latency.

Test Plan:
- Single fetch: icache_req_valid_i = 1 with addr 0x8000_0000, mem ready at once, rvalid 2 cycles later with 0x0000_0013 -> icache_ready_o pulses once; mem_addr_o = 0x8000_0000, mem_wen_o = 0; icache_data_o = 0x13 with a one-cycle valid; dcache outputs stay 0.
- Tie after reset: both requests held continuously -> grant order D, I, D, I. Each mem_addr_o matches its owner and each response is routed only to that owner.
- Store passthrough: dcache addr 0x100, wen = 1, wdata 0xDEADBEEF, wlen = 2, mem_req_ready_i held low 3 cycles -> mem_req_valid_o and fields stay stable for 4 cycles; dcache_data_valid_o pulses after the ack; no icache grant meanwhile.
- Flush in WAIT: fetch outstanding, icache_flush_i pulsed, rvalid 0x1234 -> icache_data_valid_o stays 0 and icache_data_o keeps its old value; the next pending request is granted in the following IDLE cycle.
- Flush in IDLE: icache_req_valid_i = 1 and flush = 1 -> icache_ready_o = 0, no mem request. With dcache also pending, D is granted.
- Reset mid-WAIT: rst = 1 for 1 cycle during WAIT -> all outputs 0 next cycle, state IDLE; a late mem_rvalid_i is ignored and no data_valid_o is produced.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between fetch and load/store,
// one transaction outstanding, with fetch responses droppable on branch redirect.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req_valid_i,
  input  logic [ADDR_W-1:0] icache_addr_i,
  input  logic              icache_flush_i,
  output logic              icache_ready_o,
  output logic              icache_data_valid_o,
  output logic [DATA_W-1:0] icache_data_o,
  input  logic              dcache_req_valid_i,
  input  logic [ADDR_W-1:0] dcache_addr_i,
  input  logic              dcache_wen_i,
  input  logic [DATA_W-1:0] dcache_wdata_i,
  input  logic [1:0]        dcache_wlen_i,
  output logic              dcache_ready_o,
  output logic              dcache_data_valid_o,
  output logic [DATA_W-1:0] dcache_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wen_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [1:0]        mem_wlen_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;
  logic owner, last_grant, drop, fetch_req, gnt_i, gnt_d;
  always_comb begin
    fetch_req = icache_req_valid_i & ~icache_flush_i;
    gnt_d = state == IDLE && dcache_req_valid_i && (!fetch_req || !last_grant);
    gnt_i = state == IDLE && fetch_req && !gnt_d;
    state_nxt = state == IDLE ? ((gnt_i || gnt_d) ? REQ : IDLE)
              : state == REQ  ? (mem_req_ready_i ? WAIT : REQ)
              : (mem_rvalid_i ? IDLE : WAIT);
  end
  assign icache_ready_o  = gnt_i;
  assign dcache_ready_o  = gnt_d;
  assign mem_req_valid_o = state == REQ;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_ff @(posedge clk) begin
    if (rst) begin
      owner               <= 1'b0;
      last_grant          <= 1'b0;
      drop                <= 1'b0;
      mem_addr_o          <= '0;
      mem_wen_o           <= 1'b0;
      mem_wdata_o         <= '0;
      mem_wlen_o          <= 2'b0;
      icache_data_valid_o <= 1'b0;
      icache_data_o       <= '0;
      dcache_data_valid_o <= 1'b0;
      dcache_data_o       <= '0;
    end else begin
      icache_data_valid_o <= 1'b0;
      dcache_data_valid_o <= 1'b0;
      if (gnt_i || gnt_d) begin
        owner       <= gnt_d;
        last_grant  <= gnt_d;
        drop        <= 1'b0;
        mem_addr_o  <= gnt_d ? dcache_addr_i : icache_addr_i;
        mem_wen_o   <= gnt_d & dcache_wen_i;
        mem_wdata_o <= gnt_d ? dcache_wdata_i : '0;
        mem_wlen_o  <= gnt_d ? dcache_wlen_i : 2'b0;
      end
      if (state != IDLE && !owner && icache_flush_i) drop <= 1'b1;
      // a flush landing on the response cycle itself also suppresses delivery
      if (state == WAIT && mem_rvalid_i) begin
        if (owner) begin
          dcache_data_o       <= mem_rdata_i;
          dcache_data_valid_o <= 1'b1;
        end else if (!drop && !icache_flush_i) begin
          icache_data_o       <= mem_rdata_i;
          icache_data_valid_o <= 1'b1;
        end
      end
    end
  end
endmodule
